// File: rtl/uart_pkg.sv
// Shared UART framing definitions: FSM state codes, default header bytes
// and checksum width.
package uart_pkg;

   localparam int unsigned C_BYTE_W = 8;
   localparam int unsigned C_CHK_W  = 8;

   localparam logic [C_BYTE_W-1:0] C_HDR0 = 8'h55;
   localparam logic [C_BYTE_W-1:0] C_HDR1 = 8'hAA;

   typedef logic [2:0]         state_t;
   typedef logic [C_CHK_W-1:0] chk_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_HDR1    = 3'd1;
   localparam state_t ST_LEN     = 3'd2;
   localparam state_t ST_PAYLOAD = 3'd3;
   localparam state_t ST_CHK     = 3'd4;
   localparam state_t ST_OUT     = 3'd5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: single write port, combinational read port. Contents are
// not reset; only bytes of a verified frame are ever read out.
module uart_frame_buf
   import uart_pkg::*;
#(
   parameter int unsigned P_DEPTH = 16,
   parameter int unsigned P_AW    = 4
) (
   input  logic                w_user_clk,
   input  logic                wr_en,
   input  logic [P_AW-1:0]     wr_addr,
   input  logic [C_BYTE_W-1:0] wr_data,
   input  logic [P_AW-1:0]     rd_addr,
   output logic [C_BYTE_W-1:0] rd_data
);

   logic [C_BYTE_W-1:0] mem [P_DEPTH];

   always_ff @(posedge w_user_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_rx.sv
// Receive framing layer: header hunt, length-prefixed payload capture,
// additive checksum check and valid/ready release of good payloads.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter logic [7:0]  P_HDR0        = C_HDR0,
   parameter logic [7:0]  P_HDR1        = C_HDR1,
   parameter int unsigned P_MAX_LEN     = 16,
   parameter int unsigned P_TIMEOUT_CYC = 43400
) (
   input  logic                               w_user_clk,
   input  logic                               w_user_rst,
   input  logic [7:0]                         i_rx_data,
   input  logic                               i_rx_valid,
   output logic [7:0]                         o_frame_data,
   output logic                               o_frame_valid,
   output logic                               o_frame_last,
   input  logic                               i_frame_ready,
   output logic [$clog2(P_MAX_LEN+1)-1:0]     o_frame_len,
   output logic                               o_frame_done,
   output logic                               o_chk_err,
   output logic                               o_len_err,
   output logic                               o_timeout,
   output logic                               o_overrun
);

   localparam int unsigned LW = $clog2(P_MAX_LEN + 1);
   localparam int unsigned AW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
   localparam int unsigned TW = $clog2(P_TIMEOUT_CYC + 1);

   state_t          state_q;
   logic [LW-1:0]   len_q;
   logic [LW-1:0]   wr_cnt_q;
   logic [LW-1:0]   rd_ptr_q;
   chk_t            sum_q;
   logic [TW-1:0]   to_cnt_q;
   logic            frame_done_q;
   logic            chk_err_q;
   logic            len_err_q;
   logic            timeout_q;
   logic            overrun_q;

   logic            in_frame;
   logic            to_hit;
   logic            len_ok;
   logic            last_rd;
   logic            buf_wr_en;
   logic [7:0]      buf_rd_data;

   assign in_frame = (state_q == ST_HDR1) || (state_q == ST_LEN) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
   // A byte arriving in the expiry cycle takes precedence over the timeout.
   assign to_hit   = in_frame && !i_rx_valid && (to_cnt_q == TW'(P_TIMEOUT_CYC - 1));
   assign len_ok   = (i_rx_data != '0) && (32'(i_rx_data) <= P_MAX_LEN);
   assign last_rd  = (rd_ptr_q == len_q - 1'b1);
   assign buf_wr_en = (state_q == ST_PAYLOAD) && i_rx_valid;

   uart_frame_buf #(
      .P_DEPTH (P_MAX_LEN),
      .P_AW    (AW)
   ) u_buf (
      .w_user_clk (w_user_clk),
      .wr_en      (buf_wr_en),
      .wr_addr    (AW'(wr_cnt_q)),
      .wr_data    (i_rx_data),
      .rd_addr    (AW'(rd_ptr_q)),
      .rd_data    (buf_rd_data)
   );

   always_ff @(posedge w_user_clk or posedge w_user_rst) begin
      if (w_user_rst) begin
         to_cnt_q <= '0;
      end else if (!in_frame || i_rx_valid || to_hit) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge w_user_clk or posedge w_user_rst) begin
      if (w_user_rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         wr_cnt_q     <= '0;
         rd_ptr_q     <= '0;
         sum_q        <= '0;
         frame_done_q <= 1'b0;
         chk_err_q    <= 1'b0;
         len_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         chk_err_q    <= 1'b0;
         len_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
         if (to_hit) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (i_rx_valid && (i_rx_data == P_HDR0)) state_q <= ST_HDR1;
               end
               ST_HDR1: begin
                  if (i_rx_valid) begin
                     if (i_rx_data == P_HDR1)      state_q <= ST_LEN;
                     else if (i_rx_data != P_HDR0) state_q <= ST_IDLE;
                  end
               end
               ST_LEN: begin
                  if (i_rx_valid) begin
                     if (!len_ok) begin
                        len_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                     end else begin
                        len_q    <= LW'(i_rx_data);
                        sum_q    <= i_rx_data;
                        wr_cnt_q <= '0;
                        state_q  <= ST_PAYLOAD;
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (i_rx_valid) begin
                     sum_q    <= sum_q + i_rx_data;
                     wr_cnt_q <= wr_cnt_q + 1'b1;
                     if (wr_cnt_q == len_q - 1'b1) state_q <= ST_CHK;
                  end
               end
               ST_CHK: begin
                  if (i_rx_valid) begin
                     if (i_rx_data == sum_q) begin
                        rd_ptr_q <= '0;
                        state_q  <= ST_OUT;
                     end else begin
                        chk_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                     end
                  end
               end
               ST_OUT: begin
                  if (i_frame_ready) begin
                     if (last_rd) begin
                        state_q      <= ST_IDLE;
                        frame_done_q <= 1'b1;
                     end else begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                     end
                  end
                  // Done owns the final-handshake slot so pulses stay exclusive.
                  if (i_rx_valid && !(i_frame_ready && last_rd)) overrun_q <= 1'b1;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_frame_valid = (state_q == ST_OUT);
   assign o_frame_data  = o_frame_valid ? buf_rd_data : '0;
   assign o_frame_last  = o_frame_valid && last_rd;
   assign o_frame_len   = o_frame_valid ? len_q : '0;
   assign o_frame_done  = frame_done_q;
   assign o_chk_err     = chk_err_q;
   assign o_len_err     = len_err_q;
   assign o_timeout     = timeout_q;
   assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed frames plus randomized frame mixes,
// checked against expectations built from the frame format rules.
`timescale 1ns/1ps
module tb_uart_frame_rx;

   localparam int unsigned MAXL = 16;
   localparam int unsigned TOC  = 43400;

   typedef logic [7:0] bq_t [$];
   typedef struct {
      logic [7:0] d;
      logic       l;
      logic [4:0] n;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] frame_data;
   logic       frame_valid;
   logic       frame_last;
   logic       frame_ready;
   logic [4:0] frame_len;
   logic       frame_done;
   logic       chk_err;
   logic       len_err;
   logic       timeout;
   logic       overrun;

   always #5 clk = ~clk;

   uart_frame_rx #(
      .P_HDR0        (8'h55),
      .P_HDR1        (8'hAA),
      .P_MAX_LEN     (MAXL),
      .P_TIMEOUT_CYC (TOC)
   ) dut (
      .w_user_clk    (clk),
      .w_user_rst    (rst),
      .i_rx_data     (rx_data),
      .i_rx_valid    (rx_valid),
      .o_frame_data  (frame_data),
      .o_frame_valid (frame_valid),
      .o_frame_last  (frame_last),
      .i_frame_ready (frame_ready),
      .o_frame_len   (frame_len),
      .o_frame_done  (frame_done),
      .o_chk_err     (chk_err),
      .o_len_err     (len_err),
      .o_timeout     (timeout),
      .o_overrun     (overrun)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Ready generation: 0 random, 1 high, 2 fixed pattern, 3 low
   int unsigned mode = 1;
   int unsigned pidx = 0;
   logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial frame_ready = 1'b0;
   always @(posedge clk) begin
      #1;
      case (mode)
         0: frame_ready = ($urandom_range(0, 3) != 0);
         1: frame_ready = 1'b1;
         2: begin
            if (frame_valid && pidx < 6) begin
               frame_ready = pat[pidx];
               pidx++;
            end else begin
               frame_ready = frame_valid;
            end
         end
         default: frame_ready = 1'b0;
      endcase
   end

   // Monitor: expected-beat scoreboard, hold stability, pulse accounting
   beat_t       exp_q [$];
   int unsigned n_done = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;
   int unsigned vcyc = 0;
   logic        hold_prev = 1'b0;
   logic        last_hs_prev = 1'b0;
   logic [7:0]  pd;
   logic        pl_prev;
   logic [4:0]  pn;

   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         hold_prev    = 1'b0;
         last_hs_prev = 1'b0;
      end else begin
         check("pulse_excl", 32'($countones({frame_done, chk_err, len_err, timeout, overrun}) <= 1), 32'd1);
         check("done_after_last", 32'(frame_done), 32'(last_hs_prev));
         if (frame_done) n_done++;
         if (chk_err)    n_chk++;
         if (len_err)    n_len++;
         if (timeout)    n_to++;
         if (overrun)    n_ovr++;
         if (frame_valid) vcyc++;
         if (hold_prev) begin
            check("hold_valid", 32'(frame_valid), 32'd1);
            check("hold_data",  32'(frame_data),  32'(pd));
            check("hold_last",  32'(frame_last),  32'(pl_prev));
            check("hold_len",   32'(frame_len),   32'(pn));
         end
         last_hs_prev = 1'b0;
         if (frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'(frame_data), 32'hFFFF_FFFF);
            end else begin
               b = exp_q.pop_front();
               check("beat_data", 32'(frame_data), 32'(b.d));
               check("beat_last", 32'(frame_last), 32'(b.l));
               check("beat_len",  32'(frame_len),  32'(b.n));
               last_hs_prev = b.l;
            end
         end
         hold_prev = frame_valid && !frame_ready;
         pd        = frame_data;
         pl_prev   = frame_last;
         pn        = frame_len;
      end
   end

   function automatic bq_t mk_frame(input bq_t pl, input logic [7:0] corrupt);
      bq_t        f;
      logic [7:0] s;
      s = 8'(pl.size());
      f.push_back(8'h55);
      f.push_back(8'hAA);
      f.push_back(s);
      foreach (pl[i]) begin
         f.push_back(pl[i]);
         s = s + pl[i];
      end
      f.push_back(s ^ corrupt);
      return f;
   endfunction

   function automatic bq_t rand_pl(input int unsigned n);
      bq_t p;
      for (int unsigned i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
      return p;
   endfunction

   task automatic push_beats(input bq_t pl);
      foreach (pl[i]) exp_q.push_back('{pl[i], (i == pl.size() - 1), 5'(pl.size())});
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_bytes(input bq_t f, input int unsigned gapmax);
      foreach (f[i]) begin
         send_byte(f[i]);
         repeat ($urandom_range(0, gapmax)) @(negedge clk);
      end
   endtask

   task automatic wait_drain(input string tag);
      int unsigned i;
      for (i = 0; i < 2000; i++) begin
         if (exp_q.size() == 0 && !frame_valid) break;
         @(negedge clk);
      end
      if (i == 2000) check({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_case(input string tag, input bq_t f, input bq_t pl,
                           input int unsigned e_done, input int unsigned e_chk,
                           input int unsigned e_len);
      int unsigned s_done, s_chk, s_len, s_to, s_ovr;
      s_done = n_done; s_chk = n_chk; s_len = n_len; s_to = n_to; s_ovr = n_ovr;
      push_beats(pl);
      send_bytes(f, 3);
      wait_drain(tag);
      check({tag, "_done"},    n_done - s_done, e_done);
      check({tag, "_chk_err"}, n_chk - s_chk,   e_chk);
      check({tag, "_len_err"}, n_len - s_len,   e_len);
      check({tag, "_timeout"}, n_to - s_to,     0);
      check({tag, "_overrun"}, n_ovr - s_ovr,   0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(frame_valid), 0);
      check({tag, "_data"},  32'(frame_data),  0);
      check({tag, "_last"},  32'(frame_last),  0);
      check({tag, "_len"},   32'(frame_len),   0);
      check({tag, "_pulses"}, 32'({frame_done, chk_err, len_err, timeout, overrun}), 0);
   endtask

   initial begin
      bq_t         pl, f, e;
      int unsigned k, s_to, s_ovr, s_all, s_done, n;
      logic        got;

      rx_data  = '0;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("post_reset");

      // Good frame, ready high: three consecutive beats
      mode = 1; vcyc = 0;
      pl = '{8'h11, 8'h22, 8'h33};
      f  = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      run_case("good", f, pl, 1, 0, 0);
      check("good_valid_cycles", vcyc, 3);

      // Backpressure with pattern 1,0,0,1,0,1
      mode = 2; pidx = 0; vcyc = 0;
      run_case("bp", f, pl, 1, 0, 0);
      check("bp_valid_cycles", vcyc, 6);

      // Bad checksum then good single-byte frame
      mode = 1;
      run_case("badchk", '{8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h04}, e, 0, 1, 0);
      run_case("after_badchk", '{8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F}, '{8'h7E}, 1, 0, 0);

      // Oversize length, then header resync on a repeated 55
      run_case("len17", '{8'h55, 8'hAA, 8'h11}, e, 0, 0, 1);
      run_case("len0",  '{8'h55, 8'hAA, 8'h00}, e, 0, 0, 1);
      run_case("resync", '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h00, 8'h01}, '{8'h00}, 1, 0, 0);

      // Inter-byte timeout: pulse after exactly TOC idle cycles
      s_to = n_to; s_all = n_done + n_chk + n_len + n_ovr;
      send_bytes('{8'h55, 8'hAA, 8'h02, 8'h10}, 0);
      k = 0; got = 1'b0;
      for (int unsigned i = 0; i < TOC + 20; i++) begin
         @(negedge clk);
         k++;
         if (timeout) begin
            got = 1'b1;
            break;
         end
      end
      check("timeout_seen", 32'(got), 1);
      check("timeout_latency", k, TOC);
      repeat (3) @(negedge clk);
      check("timeout_count", n_to - s_to, 1);
      check("timeout_no_other", n_done + n_chk + n_len + n_ovr - s_all, 0);
      pl = rand_pl(5);
      run_case("after_timeout", mk_frame(pl, 8'h00), pl, 1, 0, 0);

      // Overrun: full-size frame held with ready low, three bytes discarded
      mode = 3;
      pl = rand_pl(MAXL);
      push_beats(pl);
      send_bytes(mk_frame(pl, 8'h00), 2);
      for (int unsigned i = 0; i < 50 && !frame_valid; i++) @(negedge clk);
      check("ovr_valid_up", 32'(frame_valid), 1);
      s_ovr = n_ovr; s_done = n_done;
      send_bytes('{8'h55, 8'hAA, 8'h01}, 2);
      repeat (2) @(negedge clk);
      check("overrun_count", n_ovr - s_ovr, 3);
      mode = 0;
      wait_drain("ovr");
      check("ovr_done", n_done - s_done, 1);
      check("ovr_no_hunt", 32'(frame_valid), 0);

      // Reset mid-output: outputs clear without waiting for a clock edge
      mode = 3;
      pl = rand_pl(4);
      send_bytes(mk_frame(pl, 8'h00), 1);
      for (int unsigned i = 0; i < 50 && !frame_valid; i++) @(negedge clk);
      check("rst_valid_up", 32'(frame_valid), 1);
      s_all = n_done + n_chk + n_len + n_to + n_ovr;
      #2 rst = 1'b1;
      #1 check_all_zero("async_rst");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_no_pulse", n_done + n_chk + n_len + n_to + n_ovr - s_all, 0);
      check_all_zero("after_rst");
      mode = 0;
      pl = rand_pl(1);
      run_case("after_rst_frame", mk_frame(pl, 8'h00), pl, 1, 0, 0);

      // Randomized frame mix with random backpressure
      mode = 0;
      for (int unsigned it = 0; it < 150; it++) begin
         k = $urandom_range(0, 9);
         n = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 1) ? MAXL : 1)
                                         : $urandom_range(1, MAXL);
         pl = rand_pl(n);
         if (k <= 4) begin
            run_case("rnd_good", mk_frame(pl, 8'h00), pl, 1, 0, 0);
         end else if (k <= 6) begin
            run_case("rnd_badchk", mk_frame(pl, 8'($urandom_range(1, 255))), e, 0, 1, 0);
         end else if (k == 7) begin
            f = '{8'h55, 8'hAA, 8'h00};
            if ($urandom_range(0, 1) == 1) f[2] = 8'($urandom_range(MAXL + 1, 255));
            run_case("rnd_badlen", f, e, 0, 0, 1);
         end else if (k == 8) begin
            f = mk_frame(pl, 8'h00);
            for (int unsigned j = 0; j < $urandom_range(1, 4); j++) begin
               logic [7:0] jb;
               jb = 8'($urandom_range(0, 255));
               if (jb == 8'h55) jb = 8'h00;
               f.push_front(jb);
            end
            run_case("rnd_junk", f, pl, 1, 0, 0);
         end else begin
            f = mk_frame(pl, 8'h00);
            f.push_front(8'h55);
            run_case("rnd_resync", f, pl, 1, 0, 0);
         end
      end

      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
